vedic_mac_sequencer: RTL and testbench
======================================

// Module: vedic_mac_sequencer
// PURPOSE
//  Multi-cycle multiply-accumulate controller for the NPU MAC unit. Accepts WIDTH-bit unsigned
//  operand pairs over a valid/ready handshake and time-multiplexes one Vedic_2x2 core over all
//  2-bit digit pairs, forming the full 2*WIDTH product by shift-add. Adds the product into a
//  running accumulator and returns it over a second valid/ready handshake. Sits between the
//  PE operand feeder and the result writeback path.
// PARAMETERS
//  WIDTH      8   operand width in bits; even, >= 2; D = WIDTH/2 digits per operand
//  ACC_WIDTH  24  accumulator width in bits; must be >= 2*WIDTH
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          operand pair valid
//  in_ready   out  1          block can accept an operand pair
//  in_a       in   WIDTH      multiplicand, unsigned
//  in_b       in   WIDTH      multiplier, unsigned
//  in_clr     in   1          zero the accumulator before adding this product
//  out_valid  out  1          out_acc holds the result of the last accepted pair
//  out_ready  in   1          downstream accepts the result
//  out_acc    out  ACC_WIDTH  accumulator register, driven continuously
//  out_ovf    out  1          sticky accumulator wrap flag
//  busy       out  1          high in every state other than IDLE
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low.
//  Reset values: state=IDLE, out_acc=0, out_ovf=0, out_valid=0, busy=0. in_ready=1 after
//   rst_n deasserts. Inputs are ignored while rst_n is low.
//  FSM: IDLE -> MUL -> ACC -> DONE -> IDLE.
//   IDLE: in_ready=1. Accept on in_valid & in_ready: latch a, b, clr; clear prod (2*WIDTH).
//    Clear digit counters i, j. If a==0 or b==0, go to ACC with prod=0. Otherwise go to MUL.
//   MUL: one digit pair per cycle: prod += Vedic_2x2(a[2i+1:2i], b[2j+1:2j]) << 2*(i+j).
//    j is the inner counter and i the outer, each 0..D-1. After step (D-1,D-1), go to ACC.
//    This takes D*D cycles. prod is exact; no truncation.
//   ACC: out_acc <= (clr ? 0 : out_acc) + zero_extend(prod), modulo 2^ACC_WIDTH.
//    A carry out of bit ACC_WIDTH-1 sets out_ovf. Go to DONE.
//   DONE: out_valid=1. out_acc and out_ovf are held stable until out_ready=1.
//    On the out_ready edge, go to IDLE and drop out_valid.
//  out_ovf: sticky across non-clearing ops. An accepted pair with in_clr=1 clears it in ACC
//   before that op's own carry is evaluated.
//  Latency, counted in edges after the accept edge: out_valid is high after edge D*D+1
//   (17 for WIDTH=8). Zero-operand skip: after edge 1.
//  Throughput: in_ready is low from accept until the DONE->IDLE edge. No overlap.
//  Backpressure: out_ready may be low indefinitely. The FSM stalls in DONE with out_acc,
//   out_ovf and out_valid constant.
//  Reset mid-operation, in any state: immediate return to the reset values. The partial prod
//   and the latched operands are discarded. No out_valid is produced for the in-flight pair.
//  out_ready high while not in DONE has no effect. in_valid while in_ready=0 is ignored;
//   the source must hold its data.
// STRUCTURE
//  Package mac_npu_pkg: FSM state enum (IDLE, MUL, ACC, DONE).
//   Function digits(WIDTH) = WIDTH/2; counter width localparam $clog2(D).
//  Sub-module: one existing Vedic_2x2 instance as the digit multiplier. No other instances.
//  Operand digit select, shifter and prod adder are local combinational logic.
// TESTING
//  1 Reset: rst_n=0 for 3 cycles -> out_valid=0, out_acc=0, out_ovf=0, busy=0; in_ready=1
//    after release.
//  2 Full product: a=8'hFF, b=8'hFF, clr=1 -> busy for 17 edges; out_valid then high;
//    out_acc=24'h00FE01.
//  3 MAC chain: (3,5,clr=1), (7,9,clr=0), (255,2,clr=0) -> out_acc 15, then 78, then 588;
//    out_ovf=0.
//  4 Zero skip: a=0, b=8'hAB, clr=0 after test 3 -> out_valid after 1 edge; out_acc stays 588.
//  5 Overflow (ACC_WIDTH=16): FF*FF clr=1, then FF*FF clr=0 -> out_acc=16'hFC02, out_ovf=1.
//    Then 1*1 clr=1 -> out_acc=1, out_ovf=0.
//  6 Stall and abort: hold out_ready=0 for 10 cycles in DONE -> out_acc stable, in_ready=0.
//    Assert rst_n=0 during MUL step 5 of the next op -> IDLE, out_acc=0, no out_valid.

Source files
------------

// File: rtl/mac_npu_pkg.sv
// Shared types and sizing helpers for the NPU MAC sequencer.
package mac_npu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } mac_state_e;

  function automatic int digits(input int width);
    return width / 2;
  endfunction

  // A single-digit operand still needs a one-bit counter to stay synthesizable.
  function automatic int cnt_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/vedic_mac_sequencer_if.sv
// Operand and result handshake bundle between the PE feeder, the MAC sequencer and writeback.
interface vedic_mac_sequencer_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_clr;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_acc;
  logic                 out_ovf;
  logic                 busy;

  modport master (
    output in_valid, in_a, in_b, in_clr, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_clr, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, busy
  );
endinterface

// File: rtl/Vedic_2x2.sv
// Vedic (Urdhva Tiryagbhyam) 2x2-bit unsigned multiplier core.
module Vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic cross_carry;

  always_comb begin
    cross_carry = (a[1] & b[0]) & (a[0] & b[1]);
    p[0] = a[0] & b[0];
    p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    p[2] = (a[1] & b[1]) ^ cross_carry;
    p[3] = (a[1] & b[1]) & cross_carry;
  end
endmodule

// File: rtl/vedic_mac_sequencer.sv
// Multi-cycle MAC: one Vedic 2x2 core swept over all digit pairs, shift-add into prod,
// then a wrapping accumulate with a sticky overflow flag.
module vedic_mac_sequencer
  import mac_npu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vedic_mac_sequencer_if.slave  bus
);

  localparam int D  = digits(WIDTH);
  localparam int CW = cnt_width(D);
  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_MUL  = MUL;
  localparam logic [1:0] S_ACC  = ACC;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [CW-1:0] LAST_DIGIT = CW'(D - 1);

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        i_q, i_d;
  logic [CW-1:0]        j_q, j_d;
  logic                 clr_q, clr_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;

  logic [1:0]           a_dig, b_dig;
  logic [3:0]           pp;
  logic [CW+1:0]        shamt;
  logic [PW-1:0]        term;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH:0]   acc_sum;

  Vedic_2x2 u_digit_mul (
    .a (a_dig),
    .b (b_dig),
    .p (pp)
  );

  always_comb begin
    a_dig    = a_q[{i_q, 1'b0} +: 2];
    b_dig    = b_q[{j_q, 1'b0} +: 2];
    shamt    = {(CW + 1)'(i_q) + (CW + 1)'(j_q), 1'b0};
    term     = PW'(pp) << shamt;
    acc_base = clr_q ? '0 : acc_q;
    acc_sum  = {1'b0, acc_base} + (ACC_WIDTH + 1)'(prod_q);

    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    clr_d   = clr_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d    = bus.in_a;
          b_d    = bus.in_b;
          clr_d  = bus.in_clr;
          prod_d = '0;
          i_d    = '0;
          j_d    = '0;
          // A zero operand makes the digit sweep pointless; prod is already zero.
          state_d = ((bus.in_a == '0) || (bus.in_b == '0)) ? S_ACC : S_MUL;
        end
      end
      S_MUL: begin
        prod_d = prod_q + term;
        if (j_q == LAST_DIGIT) begin
          j_d = '0;
          if (i_q == LAST_DIGIT) begin
            state_d = S_ACC;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_ACC: begin
        acc_d   = acc_sum[ACC_WIDTH-1:0];
        // A clearing op drops the old sticky flag before its own carry is folded in.
        ovf_d   = (clr_q ? 1'b0 : ovf_q) | acc_sum[ACC_WIDTH];
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      clr_q   <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      clr_q   <= clr_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand and product registers are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    prod_q <= prod_d;
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_acc   = acc_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_vedic_mac_sequencer.sv
// Scoreboard bench: directed MAC ops on a 24-bit and a 16-bit accumulator instance.
module tb_vedic_mac_sequencer;

  logic clk;
  logic rst_n;

  int compared;
  int mismatched;

  typedef struct {
    logic [23:0] acc;
    logic        ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  vedic_mac_sequencer_if #(.WIDTH(8), .ACC_WIDTH(24)) bus0 ();
  vedic_mac_sequencer_if #(.WIDTH(8), .ACC_WIDTH(16)) bus1 ();

  vedic_mac_sequencer #(.WIDTH(8), .ACC_WIDTH(24)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  vedic_mac_sequencer #(.WIDTH(8), .ACC_WIDTH(16)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus0.out_valid && bus0.out_ready) begin
        if (q0.size() == 0) begin
          check("unexpected_valid0", 32'd1, 32'd0);
        end else begin
          e = q0.pop_front();
          check("acc0", 32'(bus0.out_acc), 32'(e.acc));
          check("ovf0", 32'(bus0.out_ovf), 32'(e.ovf));
        end
      end
      if (rst_n && bus1.out_valid && bus1.out_ready) begin
        if (q1.size() == 0) begin
          check("unexpected_valid1", 32'd1, 32'd0);
        end else begin
          e = q1.pop_front();
          check("acc1", 32'(bus1.out_acc), 32'(e.acc));
          check("ovf1", 32'(bus1.out_ovf), 32'(e.ovf));
        end
      end
    end
  end

  task automatic op(input bit sel, input logic [7:0] a, input logic [7:0] b, input bit clr,
                    input logic [23:0] eacc, input bit eovf, input int elat);
    int n;
    int lat;
    exp_t e;
    n = 0;
    while (!(sel ? bus1.in_ready : bus0.in_ready) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("in_ready_timeout", 32'd0, 32'd1);
    e.acc = eacc;
    e.ovf = eovf;
    if (sel) begin
      bus1.in_valid = 1'b1; bus1.in_a = a; bus1.in_b = b; bus1.in_clr = clr;
      q1.push_back(e);
    end else begin
      bus0.in_valid = 1'b1; bus0.in_a = a; bus0.in_b = b; bus0.in_clr = clr;
      q0.push_back(e);
    end
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!(sel ? bus1.out_valid : bus0.out_valid) && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), 32'(elat));
    if (sel ? bus1.out_ready : bus0.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_clr = 1'b0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_clr = 1'b0; bus1.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid0", 32'(bus0.out_valid), 32'd0);
    check("rst_acc0",   32'(bus0.out_acc),   32'd0);
    check("rst_ovf0",   32'(bus0.out_ovf),   32'd0);
    check("rst_busy0",  32'(bus0.busy),      32'd0);
    check("rst_acc1",   32'(bus1.out_acc),   32'd0);
    check("rst_busy1",  32'(bus1.busy),      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready0", 32'(bus0.in_ready), 32'd1);
    check("rel_in_ready1", 32'(bus1.in_ready), 32'd1);

    op(1'b0, 8'hFF, 8'hFF, 1'b1, 24'h00FE01, 1'b0, 17);

    op(1'b0, 8'd3,   8'd5, 1'b1, 24'd15,  1'b0, 17);
    op(1'b0, 8'd7,   8'd9, 1'b0, 24'd78,  1'b0, 17);
    op(1'b0, 8'd255, 8'd2, 1'b0, 24'd588, 1'b0, 17);

    op(1'b0, 8'h00, 8'hAB, 1'b0, 24'd588, 1'b0, 1);

    op(1'b1, 8'hFF, 8'hFF, 1'b1, 24'h00FE01, 1'b0, 17);
    op(1'b1, 8'hFF, 8'hFF, 1'b0, 24'h00FC02, 1'b1, 17);
    op(1'b1, 8'h01, 8'h01, 1'b1, 24'd1,      1'b0, 17);

    bus0.out_ready = 1'b0;
    op(1'b0, 8'd2, 8'd3, 1'b1, 24'd6, 1'b0, 17);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("stall_acc",      32'(bus0.out_acc),   32'd6);
      check("stall_in_ready", 32'(bus0.in_ready),  32'd0);
      check("stall_valid",    32'(bus0.out_valid), 32'd1);
    end
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_stall_in_ready", 32'(bus0.in_ready), 32'd1);

    bus0.in_valid = 1'b1; bus0.in_a = 8'h12; bus0.in_b = 8'h34; bus0.in_clr = 1'b0;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_busy_mul", 32'(bus0.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_acc",      32'(bus0.out_acc),   32'd0);
    check("abort_valid",    32'(bus0.out_valid), 32'd0);
    check("abort_busy",     32'(bus0.busy),      32'd0);
    check("abort_ovf",      32'(bus0.out_ovf),   32'd0);
    check("abort_in_ready", 32'(bus0.in_ready),  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_valid", 32'(bus0.out_valid), 32'd0);

    op(1'b0, 8'h12, 8'h34, 1'b0, 24'd936, 1'b0, 17);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty0", 32'(q0.size()), 32'd0);
    check("scoreboard_empty1", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
